boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
- Upstream stage of the multicycle CPU. Holds the CPU core in reset while it receives a program image as a byte stream.
- Assembles the bytes into 32-bit big-endian words and writes them into the unified instruction/data memory.
- Releases the CPU once the image is fully loaded.
- `cpu_run` drives the CPU's reset release; `mem_*` share the memory's write port while the CPU is halted.

Parameters:
- ADDR_W, 8, word-address width of the memory.
- BASE_ADDR, 0, word address of the first program word.
- MAX_WORDS, 256, largest accepted word count; must be ≤ 2**ADDR_W − BASE_ADDR.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  incoming image byte.
- rx_valid  in  1  rx_data is valid this cycle.
- rx_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  memory write strobe, one-cycle pulse.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  32  memory write data.
- cpu_run  out  1  1 = CPU released from reset.
- busy  out  1  loading is in progress.
- err  out  1  image rejected; sticky until reset.

Behaviour:
- Reset (reset=0, asynchronous): state=HDR.
  - All outputs 0: rx_ready, mem_we, mem_addr, mem_wdata, cpu_run, busy, err.
  - Byte counter, word index, shift register and checksum cleared.
  - Reset asserted mid-operation aborts the load immediately; the partially written memory is not cleaned up.
- Handshake: a byte is accepted in a cycle where rx_valid && rx_ready. rx_valid may drop at any time; gaps are unlimited.
- Byte order: bytes are shifted into a 32-bit register MSB-first (byte 0 becomes bits [31:24]). A 2-bit byte counter wraps after 4 bytes.
- States:
  - HDR: rx_ready=1, busy=1. Collect 4 bytes into the word count N.
    - N=0 → DONE (or CSUM when enabled).
    - N>MAX_WORDS → ERR.
    - Otherwise → LOAD with index=0.
  - LOAD: rx_ready=1, busy=1. On acceptance of the 4th byte of a word in cycle t:
    - In t+1: mem_we=1, mem_addr=BASE_ADDR+index, mem_wdata=assembled word.
    - index increments.
    - The next byte may be accepted in t+1; there are no wait states.
    - After the write of word N−1 → DONE (or CSUM), entered at t+1.
  - DONE: cpu_run=1 from the cycle after the last mem_we (or the cycle after the header for N=0). rx_ready=0, busy=0. Held until reset.
  - ERR: err=1, cpu_run=0, rx_ready=0, busy=0. Held until reset.
- mem_we is 0 in every cycle other than the write cycle.
- mem_addr and mem_wdata hold their last values between writes.
- Width rules:
  - Header compared as unsigned 32-bit.
  - index is wide enough for MAX_WORDS.
  - Address = BASE_ADDR + index, truncated to ADDR_W; it never wraps for legal parameters.
- Bytes presented in DONE or ERR are never accepted.

Optional Feature:
- Macro: BOOT_LOADER_CHECKSUM_EN.
- Defined:
  - A 32-bit running XOR of all N data words is kept (the header is excluded).
  - After the last write (or after the header when N=0), state CSUM (rx_ready=1, busy=1) collects a 4-byte trailer word.
  - Trailer equal to the XOR → DONE. Trailer not equal → ERR.
  - cpu_run rises the cycle after the 4th trailer byte is accepted, on a match.
- Undefined: there is no CSUM state and no trailer; behaviour is exactly as described above.

Test Plan:
- Image 00000002, 20080005, 2009000A with rx_valid held high, BASE_ADDR=0 → 2 mem_we pulses: addr 0/20080005, addr 1/2009000A. cpu_run=1 one cycle after the second pulse. err=0.
- Header 00000000 → no mem_we. cpu_run=1 the cycle after the 4th header byte is accepted (checksum off).
- Header 00000101 with MAX_WORDS=256 → err=1 the cycle after the 4th header byte. rx_ready=0. cpu_run stays 0.
- Same 2-word image with random 0–5 cycle rx_valid gaps → identical writes and values. No byte is lost or duplicated.
- reset pulled low during the 3rd byte of word 1, then released, then the full image resent → outputs clear during reset. The final writes match the clean run and cpu_run=1.
- BOOT_LOADER_CHECKSUM_EN defined, 2-word image:
  - Trailer 0001000F → cpu_run=1.
  - Trailer 00000000 → err=1, cpu_run=0.

Source files
------------

// File: rtl/boot_loader.sv
// Boot loader: receives a byte-stream program image, writes it as big-endian words into memory, then releases the CPU.
// Define BOOT_LOADER_CHECKSUM_EN to require a 4-byte XOR trailer after the data words.
module boot_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              err
);
    localparam int IDX_W = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {
        S_HDR,
        S_LOAD,
`ifdef BOOT_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam state_t S_FIN = S_CSUM;
`else
    localparam state_t S_FIN = S_DONE;
`endif

    state_t             state, state_nxt;
    logic [1:0]         bcnt;
    logic [23:0]        shreg;
    logic [31:0]        count;
    logic [IDX_W-1:0]   index;
    logic [31:0]        word;
    logic               accept, word_done, last_word, loading;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [31:0]        csum;
`endif

    // the incoming byte completes the word combinationally so it can be
    // acted on in the same cycle it is accepted
    assign word      = {shreg, rx_data};
    assign accept    = rx_valid && rx_ready;
    assign word_done = accept && (bcnt == 2'd3);
    assign last_word = (32'(index) + 32'd1) == count;

    always_comb begin
        loading = 1'b0;
        case (state)
            S_HDR, S_LOAD: loading = 1'b1;
`ifdef BOOT_LOADER_CHECKSUM_EN
            S_CSUM:        loading = 1'b1;
`endif
            default:       loading = 1'b0;
        endcase
    end

    // reset gating keeps rx_ready/busy low while reset is held
    assign rx_ready = reset && loading;
    assign busy     = reset && loading;
    assign err      = (state == S_ERR);
    assign cpu_run  = (state == S_DONE) && !mem_we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_HDR;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_HDR: begin
                if (word_done) begin
                    if (word == 32'd0)                   state_nxt = S_FIN;
                    else if (word > 32'(MAX_WORDS))      state_nxt = S_ERR;
                    else                                 state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (word_done && last_word) state_nxt = S_FIN;
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (word_done) state_nxt = (word == csum) ? S_DONE : S_ERR;
            end
`endif
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcnt      <= 2'd0;
            shreg     <= 24'd0;
            count     <= 32'd0;
            index     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum      <= 32'd0;
`endif
        end else begin
            mem_we <= 1'b0;
            if (accept) begin
                shreg <= word[23:0];
                bcnt  <= bcnt + 2'd1;
            end
            if (word_done) begin
                case (state)
                    S_HDR: begin
                        count <= word;
                        index <= '0;
                    end
                    S_LOAD: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= ADDR_W'(BASE_ADDR) + ADDR_W'(index);
                        mem_wdata <= word;
                        index     <= index + IDX_W'(1);
`ifdef BOOT_LOADER_CHECKSUM_EN
                        csum      <= csum ^ word;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: cycle table for a clean load plus hand sequences for gaps, errors and mid-load reset.
module tb_boot_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready, mem_we, cpu_run, busy, err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        valid;
        logic [7:0]  data;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        run;
        logic        err;
        logic        rdy;
        logic        busy;
    } vec_t;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    vec_t vec [14];
    wr_t  wq [$];

    boot_loader #(.ADDR_W(8), .BASE_ADDR(0), .MAX_WORDS(256)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_run(cpu_run), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) wq.push_back('{mem_addr, mem_wdata});
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        if (rx_ready !== 1'b1) chk("ready_for_byte", {63'd0, rx_ready}, 64'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int b = 3; b >= 0; b--)
            send_byte(w[8*b +: 8], $urandom_range(0, maxgap));
    endtask

    task automatic send_image(input int maxgap);
        send_word(32'h0000_0002, maxgap);
        send_word(32'h2008_0005, maxgap);
        send_word(32'h2009_000A, maxgap);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic chk_writes(input string tag);
        chk({tag, "_nwr"}, 64'(wq.size()), 64'd2);
        if (wq.size() >= 2) begin
            chk({tag, "_wr0"}, {24'd0, wq[0].a, wq[0].d}, {24'd0, 8'h00, 32'h2008_0005});
            chk({tag, "_wr1"}, {24'd0, wq[1].a, wq[1].d}, {24'd0, 8'h01, 32'h2009_000A});
        end
    endtask

    initial begin
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {21'd0, rx_ready, mem_we, mem_addr, mem_wdata, cpu_run, busy, err}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("hdr_ready", {62'd0, rx_ready, busy}, 64'd3);

`ifndef BOOT_LOADER_CHECKSUM_EN
        // clean load, rx_valid held high; outputs sampled after each edge
        vec[0]  = '{1'b1, 8'h00, 1'b0, 8'h00, 32'h0,          1'b0, 1'b0, 1'b1, 1'b1};
        vec[1]  = '{1'b1, 8'h00, 1'b0, 8'h00, 32'h0,          1'b0, 1'b0, 1'b1, 1'b1};
        vec[2]  = '{1'b1, 8'h00, 1'b0, 8'h00, 32'h0,          1'b0, 1'b0, 1'b1, 1'b1};
        vec[3]  = '{1'b1, 8'h02, 1'b0, 8'h00, 32'h0,          1'b0, 1'b0, 1'b1, 1'b1};
        vec[4]  = '{1'b1, 8'h20, 1'b0, 8'h00, 32'h0,          1'b0, 1'b0, 1'b1, 1'b1};
        vec[5]  = '{1'b1, 8'h08, 1'b0, 8'h00, 32'h0,          1'b0, 1'b0, 1'b1, 1'b1};
        vec[6]  = '{1'b1, 8'h00, 1'b0, 8'h00, 32'h0,          1'b0, 1'b0, 1'b1, 1'b1};
        vec[7]  = '{1'b1, 8'h05, 1'b1, 8'h00, 32'h2008_0005, 1'b0, 1'b0, 1'b1, 1'b1};
        vec[8]  = '{1'b1, 8'h20, 1'b0, 8'h00, 32'h2008_0005, 1'b0, 1'b0, 1'b1, 1'b1};
        vec[9]  = '{1'b1, 8'h09, 1'b0, 8'h00, 32'h2008_0005, 1'b0, 1'b0, 1'b1, 1'b1};
        vec[10] = '{1'b1, 8'h00, 1'b0, 8'h00, 32'h2008_0005, 1'b0, 1'b0, 1'b1, 1'b1};
        vec[11] = '{1'b1, 8'h0A, 1'b1, 8'h01, 32'h2009_000A, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[12] = '{1'b0, 8'h00, 1'b0, 8'h01, 32'h2009_000A, 1'b1, 1'b0, 1'b0, 1'b0};
        vec[13] = '{1'b1, 8'hFF, 1'b0, 8'h01, 32'h2009_000A, 1'b1, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            rx_valid = vec[i].valid;
            rx_data  = vec[i].data;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i),
                {19'd0, mem_we, mem_addr, mem_wdata, cpu_run, err, rx_ready, busy},
                {19'd0, vec[i].we, vec[i].addr, vec[i].wdata, vec[i].run, vec[i].err, vec[i].rdy, vec[i].busy});
        end
        rx_valid = 1'b0;

        // zero-length image
        do_reset();
        wq.delete();
        send_word(32'h0, 0);
        chk("n0_run", {63'd0, cpu_run}, 64'd1);
        chk("n0_ready", {62'd0, rx_ready, busy}, 64'd0);
        chk("n0_nwr", 64'(wq.size()), 64'd0);

        // oversize header
        do_reset();
        send_word(32'h0000_0101, 0);
        chk("big_err", {61'd0, err, rx_ready, cpu_run}, 64'h4);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        chk("big_hold", {60'd0, err, rx_ready, cpu_run, busy}, 64'h8);
        rx_valid = 1'b0;

        // random gaps between bytes
        do_reset();
        wq.delete();
        send_image(5);
        chk("gap_last", {62'd0, mem_we, cpu_run}, 64'h2);
        @(posedge clk);
        #1;
        chk("gap_run", {61'd0, mem_we, cpu_run, err}, 64'h2);
        chk_writes("gap");

        // reset during the 3rd byte of word 1, then a full resend
        do_reset();
        send_word(32'h0000_0002, 0);
        send_word(32'h2008_0005, 0);
        send_byte(8'h20, 0);
        send_byte(8'h09, 0);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h00;
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_outs", {21'd0, rx_ready, mem_we, mem_addr, mem_wdata, cpu_run, busy, err}, 64'd0);
        rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        wq.delete();
        send_image(2);
        @(posedge clk);
        #1;
        chk("midrst_run", {62'd0, cpu_run, err}, 64'h2);
        chk_writes("midrst");
`else
        // matching trailer
        do_reset();
        wq.delete();
        send_image(2);
        chk("cs_wait", {62'd0, cpu_run, rx_ready}, 64'h1);
        send_word(32'h0001_000F, 1);
        chk("cs_ok", {62'd0, cpu_run, err}, 64'h2);
        chk_writes("cs");

        // wrong trailer
        do_reset();
        send_image(0);
        send_word(32'h0000_0000, 0);
        chk("cs_bad", {62'd0, cpu_run, err}, 64'h1);

        // empty image needs a zero trailer
        do_reset();
        send_word(32'h0, 0);
        chk("cs_n0_wait", {62'd0, cpu_run, rx_ready}, 64'h1);
        send_word(32'h0, 0);
        chk("cs_n0_ok", {62'd0, cpu_run, err}, 64'h2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
